add_sub_pipe: RTL and testbench
===============================

// Module: add_sub_pipe
// PURPOSE
//   Parametrised, pipelined integer adder/subtractor for the datapath ALU.
//   Successor to the single-cycle 32-bit adder: selectable add/sub, optional
//   signed saturation, full flag set (carry/borrow, signed overflow, zero,
//   negative), and a valid/ready stream interface with backpressure.
//   The block sits between operand fetch and writeback; one operation per clock.
// PARAMETERS
//   WIDTH        32  operand/result width in bits
//   STAGES       4   pipeline stages; WIDTH % STAGES == 0; slice = WIDTH/STAGES
//   SATURATE_EN  1   0: op[1] is ignored and every op wraps
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands/op valid
//   in_ready   out  1      block can accept an operation this cycle
//   op         in   2      00 ADD, 01 SUB, 10 ADD-sat, 11 SUB-sat
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      downstream accepts result
//   result     out  WIDTH  sum/difference (saturated if selected)
//   overflow   out  2      [0] signed overflow, [1] unsigned carry (ADD) / borrow (SUB)
//   zero       out  1      result == 0
//   negative   out  1      result[WIDTH-1]
// BEHAVIOUR
//   - Reset (rst_n=0, async): all stage valid bits, out_valid, result, overflow,
//     zero and negative go to 0 at once. In-flight operations are discarded.
//     After release, in_ready=1.
//   - Accept on in_valid && in_ready. Transfer on out_valid && out_ready.
//   - stall = out_valid && !out_ready. in_ready = !stall (combinational).
//     On stall the whole pipe freezes. result and the flags hold stable.
//   - Latency: STAGES cycles from accept to out_valid when there is no stall.
//     Throughput is 1 op/cycle. Bubbles propagate as valid=0 and never block.
//   - Stage k (0..STAGES-1) adds slice k of a and b' with the carry from stage
//     k-1. Unprocessed upper slices and the already summed lower slices are
//     carried forward in registers.
//   - SUB: b' = ~b, carry-in = 1. ADD: b' = b, carry-in = 0.
//   - Wrapped result = (a + b' + cin) mod 2^WIDTH.
//   - overflow[0] = (a[MSB] == b'[MSB]) && (wrap[MSB] != a[MSB]) for every op.
//   - overflow[1] = carry-out for ADD; ~carry-out (borrow) for SUB.
//   - Saturation (op[1]=1 && SATURATE_EN): on signed overflow, result is
//     0111..1 if a[MSB]=0, else 1000..0. Flags still report the overflow.
//   - zero/negative are computed on the final (post-saturation) result.
//   - STAGES=1: a single registered stage with latency 1. All other rules unchanged.
//   - Accepting an op and popping the output in the same cycle with a full pipe
//     is legal: no loss, no duplication. Ops leave in the order they were accepted.
// TESTING
//   1 op=00 a=7FFFFFFF b=1 -> after 4 clk: result=80000000 ovf=01 neg=1 zero=0
//   2 op=10 a=7FFFFFFF b=1 -> result=7FFFFFFF ovf=01 neg=0. op=11 a=80000000 b=1 -> 80000000 ovf=01
//   3 op=01 a=0 b=1 -> result=FFFFFFFF ovf=10 neg=1. op=00 a=FFFFFFFF b=1 -> result=0 ovf=10 zero=1
//   4 16 random back-to-back ops, out_ready toggled randomly -> results match the
//     model in order; in_ready==0 exactly when out_valid && !out_ready
//   5 rst_n pulled low mid-cycle with 3 ops in flight -> out_valid=0 at once;
//     nothing stale emitted after release; the next op completes in 4 clk
//   6 Rebuild with WIDTH=8, STAGES=1 and SATURATE_EN=0: op=10 7F+01 -> 80 ovf=01, latency 1

Source files
------------

// File: rtl/add_sub_pipe_if.sv
// ============================================================================
// Module  : add_sub_pipe_if
// Brief   : Operand/result stream bundle for the pipelined adder/subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface add_sub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [1:0]       overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, zero, negative
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, overflow, zero, negative
    );
endinterface

`default_nettype wire

// File: rtl/add_sub_pipe.sv
// ============================================================================
// Module  : add_sub_pipe
// Brief   : Sliced carry-pipelined add/sub with saturation, flags and backpressure.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_pipe #(
    parameter int WIDTH       = 32,
    parameter int STAGES      = 4,
    parameter int SATURATE_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    add_sub_pipe_if.slave bus
);
    localparam int c_SW   = WIDTH / STAGES;
    localparam int c_LAST = STAGES - 1;
    localparam int c_REGS = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int c_MSB  = WIDTH - 1;
    localparam logic [WIDTH-1:0] c_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_stall;

    // Per-stage inputs (w_a .. w_sat) and the partial sum after that stage's slice.
    logic [WIDTH-1:0] w_a    [STAGES];
    logic [WIDTH-1:0] w_bp   [STAGES];
    logic [WIDTH-1:0] w_part [STAGES];
    logic [WIDTH-1:0] w_sum  [STAGES];
    logic             w_cy   [STAGES];
    logic             w_cout [STAGES];
    logic             w_vld  [STAGES];
    logic             w_sub  [STAGES];
    logic             w_sat  [STAGES];
    logic [c_SW:0]    w_slice[STAGES];

    logic [WIDTH-1:0] r_a    [c_REGS];
    logic [WIDTH-1:0] r_bp   [c_REGS];
    logic [WIDTH-1:0] r_part [c_REGS];
    logic             r_cy   [c_REGS];
    logic             r_vld  [c_REGS];
    logic             r_sub  [c_REGS];
    logic             r_sat  [c_REGS];

    logic             r_out_vld;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_res;
    logic             w_sovf;
    logic             w_uovf;

    assign w_stall      = r_out_vld && !bus.out_ready;
    assign bus.in_ready = !w_stall;

    always_comb begin
        w_a[0]    = bus.a;
        w_bp[0]   = bus.op[0] ? ~bus.b : bus.b;
        w_part[0] = '0;
        w_cy[0]   = bus.op[0];
        w_vld[0]  = bus.in_valid;
        w_sub[0]  = bus.op[0];
        w_sat[0]  = bus.op[1] && (SATURATE_EN != 0);
        for (int k = 1; k < STAGES; k++) begin
            w_a[k]    = r_a[k-1];
            w_bp[k]   = r_bp[k-1];
            w_part[k] = r_part[k-1];
            w_cy[k]   = r_cy[k-1];
            w_vld[k]  = r_vld[k-1];
            w_sub[k]  = r_sub[k-1];
            w_sat[k]  = r_sat[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_slice[k] = {1'b0, w_a[k][k*c_SW +: c_SW]}
                       + {1'b0, w_bp[k][k*c_SW +: c_SW]}
                       + {{c_SW{1'b0}}, w_cy[k]};
            w_sum[k]   = w_part[k];
            w_sum[k][k*c_SW +: c_SW] = w_slice[k][c_SW-1:0];
            w_cout[k]  = w_slice[k][c_SW];
        end
    end

    // Flags and saturation resolve in the last stage, ahead of the output register.
    always_comb begin
        w_wrap = w_sum[c_LAST];
        w_sovf = (w_a[c_LAST][c_MSB] == w_bp[c_LAST][c_MSB])
              && (w_wrap[c_MSB] != w_a[c_LAST][c_MSB]);
        w_uovf = w_sub[c_LAST] ? ~w_cout[c_LAST] : w_cout[c_LAST];
        w_res  = w_wrap;
        if (w_sat[c_LAST] && w_sovf) begin
            w_res = w_a[c_LAST][c_MSB] ? c_MIN_NEG : c_MAX_POS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_a[k]    <= '0;
                r_bp[k]   <= '0;
                r_part[k] <= '0;
                r_cy[k]   <= 1'b0;
                r_vld[k]  <= 1'b0;
                r_sub[k]  <= 1'b0;
                r_sat[k]  <= 1'b0;
            end
            r_out_vld <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 2'b00;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_a[k]    <= w_a[k];
                r_bp[k]   <= w_bp[k];
                r_part[k] <= w_sum[k];
                r_cy[k]   <= w_cout[k];
                r_vld[k]  <= w_vld[k];
                r_sub[k]  <= w_sub[k];
                r_sat[k]  <= w_sat[k];
            end
            r_out_vld <= w_vld[c_LAST];
            if (w_vld[c_LAST]) begin
                r_result <= w_res;
                r_ovf    <= {w_uovf, w_sovf};
                r_zero   <= (w_res == '0);
                r_neg    <= w_res[c_MSB];
            end
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_neg;
endmodule

`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
// ============================================================================
// Module  : tb_add_sub_pipe
// Brief   : Self-checking bench for add_sub_pipe (32b/4-stage and 8b/1-stage).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_sub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    add_sub_pipe_if #(.WIDTH(32)) bus ();
    add_sub_pipe_if #(.WIDTH(8))  bus8 ();

    add_sub_pipe #(.WIDTH(32), .STAGES(4), .SATURATE_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    add_sub_pipe #(.WIDTH(8), .STAGES(1), .SATURATE_EN(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    // Reference: exact signed/unsigned arithmetic, range-checked.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, s;
        logic [32:0] t;
        exp_t        e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = op[0] ? sa - sb : sa + sb;
        t  = {1'b0, a} + {1'b0, b};
        e.res    = op[0] ? a - b : a + b;
        e.ovf[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.ovf[1] = op[0] ? (a < b) : t[32];
        if (op[1] && e.ovf[0]) e.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.zero = (e.res == 32'h0);
        e.neg  = e.res[31];
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op with out_ready high; returns output and accept-to-valid latency.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t got, output int lat);
        bus.op = op; bus.a = a; bus.b = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        got = {bus.result, bus.overflow, bus.zero, bus.negative};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.overflow !== 2'b00
            || bus.zero !== 1'b0 || bus.negative !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b r=%h o=%b z=%b n=%b, want all 0",
                     bus.out_valid, bus.result, bus.overflow, bus.zero, bus.negative);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #2;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_vectors();
        exp_t got;
        int   lat;
        do_op(2'b00, 32'h7FFF_FFFF, 32'h1, got, lat);
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d want 4", lat); end
        n_cmp++;
        if (got !== {32'h8000_0000, 2'b01, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL add_wrap: got %h want %h", got, {32'h8000_0000, 2'b01, 1'b0, 1'b1});
        end
        do_op(2'b10, 32'h7FFF_FFFF, 32'h1, got, lat);
        n_cmp++;
        if (got !== {32'h7FFF_FFFF, 2'b01, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL add_sat: got %h want %h", got, {32'h7FFF_FFFF, 2'b01, 1'b0, 1'b0});
        end
        do_op(2'b11, 32'h8000_0000, 32'h1, got, lat);
        n_cmp++;
        if (got !== {32'h8000_0000, 2'b01, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL sub_sat: got %h want %h", got, {32'h8000_0000, 2'b01, 1'b0, 1'b1});
        end
        do_op(2'b01, 32'h0, 32'h1, got, lat);
        n_cmp++;
        if (got !== {32'hFFFF_FFFF, 2'b10, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL sub_borrow: got %h want %h", got, {32'hFFFF_FFFF, 2'b10, 1'b0, 1'b1});
        end
        do_op(2'b00, 32'hFFFF_FFFF, 32'h1, got, lat);
        n_cmp++;
        if (got !== {32'h0, 2'b10, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL add_carry_zero: got %h want %h", got, {32'h0, 2'b10, 1'b1, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   sent = 0, recv = 0, cyc = 0;
        logic acc;
        bus.op = 2'($urandom_range(0, 3)); bus.a = pick(); bus.b = pick();
        bus.in_valid = 1'b1;
        bus.out_ready = 1'($urandom_range(0, 1));
        while (recv < 16 && cyc < 400) begin
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                n_err++;
                $display("FAIL b2b_in_ready: got %b want %b", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                q.push_back(model(bus.op, bus.a, bus.b));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_output: got result %h, want none", bus.result);
                end else begin
                    e = q.pop_front();
                    if ({bus.result, bus.overflow, bus.zero, bus.negative} !== e) begin
                        n_err++;
                        $display("FAIL b2b_result#%0d: got %h want %h", recv,
                                 {bus.result, bus.overflow, bus.zero, bus.negative}, e);
                    end
                end
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent < 16) begin
                    bus.op = 2'($urandom_range(0, 3)); bus.a = pick(); bus.b = pick();
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        n_cmp++;
        if (recv != 16) begin n_err++; $display("FAIL b2b_count: got %0d want 16", recv); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_flight();
        exp_t got;
        int   lat, stale = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.op = 2'b00; bus.a = 32'(i + 1); bus.b = 32'd10; bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL flight_pre_valid: got %b want 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.overflow !== 2'b00) begin
            n_err++;
            $display("FAIL flight_async_reset: got v=%b r=%h o=%b want 0/0/0", bus.out_valid, bus.result, bus.overflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (stale != 0) begin n_err++; $display("FAIL flight_stale: got %0d outputs want 0", stale); end
        do_op(2'b00, 32'd5, 32'd6, got, lat);
        n_cmp++;
        if (lat !== 4 || got.res !== 32'd11) begin
            n_err++; $display("FAIL flight_next_op: got lat=%0d r=%h want lat=4 r=0000000b", lat, got.res);
        end
    endtask

    task automatic test_small_config();
        bus8.op = 2'b10; bus8.a = 8'h7F; bus8.b = 8'h01;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus8.out_valid !== 1'b0) begin n_err++; $display("FAIL w8_idle: got %b want 0", bus8.out_valid); end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus8.out_valid, bus8.result, bus8.overflow, bus8.zero, bus8.negative} !== {1'b1, 8'h80, 2'b01, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL w8_wrap_lat1: got v=%b r=%h o=%b z=%b n=%b want v=1 r=80 o=01 z=0 n=1",
                     bus8.out_valid, bus8.result, bus8.overflow, bus8.zero, bus8.negative);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.op = 2'b00; bus8.a = '0; bus8.b = '0;
        test_reset();
        test_fixed_vectors();
        test_back_to_back();
        test_reset_in_flight();
        test_small_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
